multicycle_controller: RTL and testbench

//  Control FSM for the multi-cycle RV32I core: sequences one shared ALU/memory datapath over 3-5 states per instruction.

---
 rtl/mc_pkg.sv | 64 ++++++
 rtl/mc_alu_decode.sv | 52 +++++
 rtl/multicycle_controller.sv | 226 ++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared types and encodings for the multi-cycle RV32I controller
//
// Purpose: FSM state enum, ALU-op enum, opcode values and datapath mux /
// ALU-control / cause encodings used by multicycle_controller and
// mc_alu_decode.
// Ports: none (package).
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_HALT
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_FUNCT
  } aluop_e;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [2:0] ALUC_ADD = 3'b000;
  localparam logic [2:0] ALUC_SUB = 3'b001;
  localparam logic [2:0] ALUC_AND = 3'b010;
  localparam logic [2:0] ALUC_OR  = 3'b011;
  localparam logic [2:0] ALUC_SLT = 3'b101;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/mc_alu_decode.sv
// rtl/mc_alu_decode.sv - ALU control and immediate-format decode
//
// Purpose: combinational translation of the FSM's ALU operation class plus
// instruction fields into the 3-bit ALU control, and of the opcode into the
// immediate format select.
// Ports:
//   i_aluop     in  ALU operation class from the FSM
//   i_op        in  7-bit opcode
//   i_funct3    in  funct3 field
//   i_funct7b5  in  instr[30]
//   o_alucrtl   out ALU control
//   o_immsrc    out immediate format select
module mc_alu_decode
  import mc_pkg::*;
(
  input  aluop_e      i_aluop,
  input  logic [6:0]  i_op,
  input  logic [2:0]  i_funct3,
  input  logic        i_funct7b5,
  output logic [2:0]  o_alucrtl,
  output logic [1:0]  o_immsrc
);

  always_comb begin
    o_alucrtl = ALUC_ADD;
    case (i_aluop)
      ALU_SUB: o_alucrtl = ALUC_SUB;
      ALU_FUNCT: begin
        case (i_funct3)
          // Only R-type (op[5]=1) can encode sub; addi ignores instr[30].
          3'b000:  o_alucrtl = (i_op[5] & i_funct7b5) ? ALUC_SUB : ALUC_ADD;
          3'b010:  o_alucrtl = ALUC_SLT;
          3'b110:  o_alucrtl = ALUC_OR;
          3'b111:  o_alucrtl = ALUC_AND;
          default: o_alucrtl = ALUC_ADD;
        endcase
      end
      default: o_alucrtl = ALUC_ADD;
    endcase
  end

  always_comb begin
    o_immsrc = IMM_I;
    case (i_op)
      OP_SW:   o_immsrc = IMM_S;
      OP_BEQ:  o_immsrc = IMM_B;
      OP_JAL:  o_immsrc = IMM_J;
      default: o_immsrc = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - control FSM for the multi-cycle RV32I core
//
// Purpose: sequences the shared ALU/memory datapath for lw, sw, R-type,
// I-type ALU, beq and jal; handshakes with one unified memory port; halts on
// illegal opcodes or memory timeouts until reset.
// Optional feature: define MC_INSTRET_CNT_EN to add the o_instret counter.
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_op/i_funct3/i_funct7b5 instruction fields
//   i_zero                 ALU zero flag
//   i_mem_ready            memory completed the current access
//   o_mem_req/o_memwrite/o_adrsrc  memory port control
//   o_irwrite/o_pcwrite/o_regwrite datapath write enables
//   o_alusrca/o_alusrcb/o_resultsrc/o_immsrc/o_alucrtl datapath selects
//   o_halted/o_cause       halt status and reason
//   o_instret              retired-instruction count (MC_INSTRET_CNT_EN only)
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 16,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [6:0]       i_op,
  input  logic [2:0]       i_funct3,
  input  logic             i_funct7b5,
  input  logic             i_zero,
  input  logic             i_mem_ready,
  output logic             o_mem_req,
  output logic             o_memwrite,
  output logic             o_adrsrc,
  output logic             o_irwrite,
  output logic             o_pcwrite,
  output logic             o_regwrite,
  output logic [1:0]       o_alusrca,
  output logic [1:0]       o_alusrcb,
  output logic [1:0]       o_resultsrc,
  output logic [1:0]       o_immsrc,
  output logic [2:0]       o_alucrtl,
  output logic             o_halted,
  output logic [1:0]       o_cause
`ifdef MC_INSTRET_CNT_EN
  ,
  output logic [CNT_W-1:0] o_instret
`endif
);

  localparam int unsigned WAIT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        cause_q, cause_d;
  logic [31:0]       wait_inc;

  logic   mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite;
  aluop_e aluop;

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    wait_d      = '0;
    wait_inc    = 32'(wait_q) + 32'd1;
    mem_req     = 1'b0;
    memwrite    = 1'b0;
    adrsrc      = 1'b0;
    irwrite     = 1'b0;
    pcwrite     = 1'b0;
    regwrite    = 1'b0;
    o_alusrca   = SRCA_PC;
    o_alusrcb   = SRCB_RS2;
    o_resultsrc = RES_ALUOUT;
    aluop       = ALU_ADD;

    case (state_q)
      S_FETCH: begin
        mem_req     = 1'b1;
        o_alusrcb   = SRCB_FOUR;
        o_resultsrc = RES_ALURESULT;
        if (i_mem_ready) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target oldPC+imm is computed here and parked in ALUOut.
        o_alusrca = SRCA_OLDPC;
        o_alusrcb = SRCB_IMM;
        case (i_op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECR;
          OP_ITYPE:     state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            state_d = S_HALT;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: begin
        o_alusrca = SRCA_RS1;
        o_alusrcb = SRCB_IMM;
        state_d   = i_op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adrsrc  = 1'b1;
        if (i_mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        o_resultsrc = RES_MEMDATA;
        regwrite    = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        memwrite = 1'b1;
        adrsrc   = 1'b1;
        if (i_mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        o_alusrca = SRCA_RS1;
        o_alusrcb = SRCB_RS2;
        aluop     = ALU_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        o_alusrca = SRCA_RS1;
        o_alusrcb = SRCB_IMM;
        aluop     = ALU_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        o_resultsrc = RES_ALUOUT;
        regwrite    = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQ: begin
        o_alusrca   = SRCA_RS1;
        o_alusrcb   = SRCB_RS2;
        aluop       = ALU_SUB;
        o_resultsrc = RES_ALUOUT;
        pcwrite     = i_zero;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms oldPC+4 for rd.
        o_alusrca   = SRCA_OLDPC;
        o_alusrcb   = SRCB_FOUR;
        o_resultsrc = RES_ALUOUT;
        pcwrite     = 1'b1;
        state_d     = S_ALUWB;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // The counter is zero whenever no access is stalled, so every memory
    // state is entered with a fresh count. Ready in the limit cycle wins.
    if (mem_req && !i_mem_ready) begin
      wait_d = wait_inc[WAIT_W-1:0];
      if (MEM_WAIT_MAX != 0 && wait_inc == 32'(MEM_WAIT_MAX)) begin
        state_d = S_HALT;
        cause_d = CAUSE_TIMEOUT;
        wait_d  = '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
    end
  end

  // Reset drops the request and every write enable in the same cycle, even
  // when it arrives in the middle of an access.
  assign o_mem_req  = mem_req  & ~i_rst;
  assign o_memwrite = memwrite & ~i_rst;
  assign o_adrsrc   = adrsrc;
  assign o_irwrite  = irwrite  & ~i_rst;
  assign o_pcwrite  = pcwrite  & ~i_rst;
  assign o_regwrite = regwrite & ~i_rst;
  assign o_halted   = (state_q == S_HALT);
  assign o_cause    = cause_q;

  mc_alu_decode u_alu_decode (
    .i_aluop    (aluop),
    .i_op       (i_op),
    .i_funct3   (i_funct3),
    .i_funct7b5 (i_funct7b5),
    .o_alucrtl  (o_alucrtl),
    .o_immsrc   (o_immsrc)
  );

`ifdef MC_INSTRET_CNT_EN
  logic [CNT_W-1:0] instret_q, instret_d;

  always_comb begin
    instret_d = instret_q;
    if (state_d == S_FETCH &&
        (state_q inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ})) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) instret_q <= '0;
    else       instret_q <= instret_d;
  end

  assign o_instret = instret_q;
`else
  logic [CNT_W-1:0] unused_instret;
  assign unused_instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized self-checking bench for multicycle_controller
module tb_multicycle_controller;

  localparam int WMAX = 16;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [6:0] i_op = 7'd0;
  logic [2:0] i_funct3 = 3'd0;
  logic       i_funct7b5 = 1'b0;
  logic       i_zero = 1'b0;
  logic       i_mem_ready = 1'b0;
  logic       o_mem_req, o_memwrite, o_adrsrc, o_irwrite, o_pcwrite, o_regwrite;
  logic [1:0] o_alusrca, o_alusrcb, o_resultsrc, o_immsrc;
  logic [2:0] o_alucrtl;
  logic       o_halted;
  logic [1:0] o_cause;
`ifdef MC_INSTRET_CNT_EN
  logic [31:0] o_instret;
`endif

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_WAIT_MAX(WMAX), .CNT_W(32)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_op        (i_op),
    .i_funct3    (i_funct3),
    .i_funct7b5  (i_funct7b5),
    .i_zero      (i_zero),
    .i_mem_ready (i_mem_ready),
    .o_mem_req   (o_mem_req),
    .o_memwrite  (o_memwrite),
    .o_adrsrc    (o_adrsrc),
    .o_irwrite   (o_irwrite),
    .o_pcwrite   (o_pcwrite),
    .o_regwrite  (o_regwrite),
    .o_alusrca   (o_alusrca),
    .o_alusrcb   (o_alusrcb),
    .o_resultsrc (o_resultsrc),
    .o_immsrc    (o_immsrc),
    .o_alucrtl   (o_alucrtl),
    .o_halted    (o_halted),
    .o_cause     (o_cause)
`ifdef MC_INSTRET_CNT_EN
    ,
    .o_instret   (o_instret)
`endif
  );

  typedef struct packed {
    logic       mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite;
    logic [1:0] srca, srcb, res, imm;
    logic [2:0] alu;
    logic       halted;
    logic [1:0] cause;
  } outv_t;

  typedef struct packed {
    logic  rst;
    logic  rdy;
    logic  zero;
    outv_t e;
  } step_t;

  step_t q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    model_instret = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] imm_of(input logic [6:0] op);
    if (op == SW)  return 2'b01;
    if (op == BEQ) return 2'b10;
    if (op == JAL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] funct_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (op[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic outv_t dut_v();
    return {o_mem_req, o_memwrite, o_adrsrc, o_irwrite, o_pcwrite, o_regwrite,
            o_alusrca, o_alusrcb, o_resultsrc, o_immsrc, o_alucrtl, o_halted, o_cause};
  endfunction

  task automatic push(input logic rst, input logic rdy, input logic zero, input outv_t e);
    step_t s;
    s.rst = rst; s.rdy = rdy; s.zero = zero; s.e = e;
    q.push_back(s);
  endtask

  // An access that is not ready for w cycles; WMAX stalled cycles end in a timeout.
  task automatic mem_phase(input outv_t wait_v, input outv_t done_v, input int w, output bit to);
    to = (w >= WMAX);
    for (int i = 0; i < (to ? WMAX : w); i++) push(1'b0, 1'b0, 1'($urandom), wait_v);
    if (!to) push(1'b0, 1'b1, 1'($urandom), done_v);
  endtask

  task automatic play(input string name);
    foreach (q[i]) begin
      i_rst       = q[i].rst;
      i_mem_ready = q[i].rdy;
      i_zero      = q[i].zero;
      @(negedge clk);
      if (q[i].rst)
        check($sformatf("%s rst_en c%0d", name, i),
              64'({o_mem_req, o_memwrite, o_irwrite, o_pcwrite, o_regwrite}), 64'd0);
      else
        check($sformatf("%s c%0d", name, i), 64'(dut_v()), 64'(q[i].e));
      @(posedge clk);
      #1;
    end
    i_rst = 1'b0;
    q.delete();
`ifdef MC_INSTRET_CNT_EN
    check($sformatf("%s instret", name), 64'(o_instret), 64'(model_instret));
`endif
  endtask

  task automatic do_reset(input string name);
    outv_t z;
    z = '0;
    push(1'b1, 1'($urandom), 1'($urandom), z);
    model_instret = 0;
    play(name);
  endtask

  // rst_at >= 0 (sw only): reset after rst_at stalled MEMWRITE cycles.
  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input int fw, input int mw, input logic z,
                           input int rst_at);
    outv_t b, e, d;
    bit    to;
    bit    retired;
    bit    was_rst;
    logic [1:0] cause;
    retired = 0; was_rst = 0; cause = 2'b00;
    i_op = op; i_funct3 = f3; i_funct7b5 = f7;
    b = '0;
    b.imm = imm_of(op);

    e = b; e.mem_req = 1; e.srcb = 2'b10; e.res = 2'b10;
    d = e; d.irwrite = 1; d.pcwrite = 1;
    mem_phase(e, d, fw, to);
    if (to) cause = 2'b10;
    else begin
      e = b; e.srca = 2'b01; e.srcb = 2'b01;
      push(1'b0, 1'($urandom), 1'($urandom), e);
      e = b; e.srca = 2'b10; e.srcb = 2'b01;
      if (op == LW) begin
        push(1'b0, 1'($urandom), 1'($urandom), e);
        e = b; e.mem_req = 1; e.adrsrc = 1;
        mem_phase(e, e, mw, to);
        if (to) cause = 2'b10;
        else begin
          e = b; e.res = 2'b01; e.regwrite = 1;
          push(1'b0, 1'($urandom), 1'($urandom), e);
          retired = 1;
        end
      end else if (op == SW) begin
        push(1'b0, 1'($urandom), 1'($urandom), e);
        e = b; e.mem_req = 1; e.memwrite = 1; e.adrsrc = 1;
        if (rst_at >= 0) begin
          for (int i = 0; i < rst_at; i++) push(1'b0, 1'b0, 1'($urandom), e);
          push(1'b1, 1'($urandom), 1'($urandom), b);
          was_rst = 1;
        end else begin
          mem_phase(e, e, mw, to);
          if (to) cause = 2'b10;
          else retired = 1;
        end
      end else if (op == RT || op == IT) begin
        e = b; e.srca = 2'b10; e.srcb = (op == IT) ? 2'b01 : 2'b00;
        e.alu = funct_alu(op, f3, f7);
        push(1'b0, 1'($urandom), 1'($urandom), e);
        e = b; e.regwrite = 1;
        push(1'b0, 1'($urandom), 1'($urandom), e);
        retired = 1;
      end else if (op == BEQ) begin
        e = b; e.srca = 2'b10; e.alu = 3'b001; e.pcwrite = z;
        push(1'b0, 1'($urandom), z, e);
        retired = 1;
      end else if (op == JAL) begin
        e = b; e.srca = 2'b01; e.srcb = 2'b10; e.pcwrite = 1;
        push(1'b0, 1'($urandom), 1'($urandom), e);
        e = b; e.regwrite = 1;
        push(1'b0, 1'($urandom), 1'($urandom), e);
        retired = 1;
      end else begin
        cause = 2'b01;
      end
    end

    if (cause != 2'b00) begin
      e = b; e.halted = 1; e.cause = cause;
      for (int i = 0; i < 3; i++) push(1'b0, 1'($urandom), 1'($urandom), e);
      push(1'b1, 1'($urandom), 1'($urandom), e);
      was_rst = 1;
    end
    if (retired) model_instret++;
    if (was_rst) model_instret = 0;
    play(name);
  endtask

  function automatic logic [6:0] rand_illegal();
    logic [6:0] op;
    do op = 7'($urandom);
    while (op inside {LW, SW, RT, IT, BEQ, JAL});
    return op;
  endfunction

  function automatic int rand_wait();
    return ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 3));
  endfunction

  initial begin
    do_reset("reset");
    run_instr("lw",        LW,  3'b010, 1'b0, 0,  0, 1'b0, -1);
    run_instr("sw_wait3",  SW,  3'b010, 1'b0, 0,  3, 1'b0, -1);
    run_instr("beq_z1",    BEQ, 3'b000, 1'b0, 0,  0, 1'b1, -1);
    run_instr("beq_z0",    BEQ, 3'b000, 1'b0, 1,  0, 1'b0, -1);
    run_instr("r_sub",     RT,  3'b000, 1'b1, 0,  0, 1'b0, -1);
    run_instr("i_add",     IT,  3'b000, 1'b1, 0,  0, 1'b0, -1);
    run_instr("r_slt",     RT,  3'b010, 1'b0, 2,  0, 1'b0, -1);
    run_instr("jal",       JAL, 3'b000, 1'b0, 0,  0, 1'b0, -1);
    run_instr("illegal",   7'b1110011, 3'b000, 1'b0, 0, 0, 1'b0, -1);
    run_instr("fetch_to",  LW,  3'b010, 1'b0, 20, 0, 1'b0, -1);
    run_instr("fetch_15",  IT,  3'b111, 1'b0, 15, 0, 1'b0, -1);
    run_instr("sw_rst",    SW,  3'b010, 1'b0, 0,  0, 1'b0, 2);
    run_instr("lw_to",     LW,  3'b010, 1'b0, 0, 16, 1'b0, -1);
    run_instr("sw_15",     SW,  3'b010, 1'b0, 0, 15, 1'b0, -1);
    for (int n = 0; n < 60; n++) begin
      int k;
      k = int'($urandom_range(0, 7));
      case (k)
        0: run_instr("r_lw",  LW,  3'($urandom), 1'($urandom), rand_wait(), rand_wait(), 1'b0, -1);
        1: run_instr("r_sw",  SW,  3'($urandom), 1'($urandom), rand_wait(), rand_wait(), 1'b0, -1);
        2: run_instr("r_rt",  RT,  3'($urandom), 1'($urandom), rand_wait(), 0, 1'b0, -1);
        3: run_instr("r_it",  IT,  3'($urandom), 1'($urandom), rand_wait(), 0, 1'b0, -1);
        4: run_instr("r_beq", BEQ, 3'($urandom), 1'($urandom), rand_wait(), 0, 1'($urandom), -1);
        5: run_instr("r_jal", JAL, 3'($urandom), 1'($urandom), rand_wait(), 0, 1'b0, -1);
        6: run_instr("r_ill", rand_illegal(), 3'($urandom), 1'($urandom), rand_wait(), 0, 1'b0, -1);
        default: run_instr("r_swrst", SW, 3'($urandom), 1'($urandom), rand_wait(), 0, 1'b0,
                           int'($urandom_range(0, 5)));
      endcase
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
